cpu_top: RTL and testbench

CPU_TOP -- requirements
Module: cpu_top

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/uart_rx.sv | 101 ++++++++++
 rtl/cpu_top.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_cpu_top.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the serial-loaded accumulator CPU.
//   * opcode constants (instruction byte0[7:4])
//   * flag bit positions inside the 5-bit flag register {HZ,N,OV,Z,C}
//   * state enums for the CPU sequencer and the UART receiver
//   * set_zn(): refresh the zero/negative flags from an ACC result
package cpu_pkg;

    localparam logic [3:0] OP_MPY   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_LOAD  = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_NOT   = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h8;
    localparam logic [3:0] OP_SHR   = 4'h9;
    localparam logic [3:0] OP_JGZ   = 4'hA;
    localparam logic [3:0] OP_SHL   = 4'hB;
    localparam logic [3:0] OP_ADD   = 4'hC;
    localparam logic [3:0] OP_JMP   = 4'hD;
    localparam logic [3:0] OP_HALT  = 4'hE;

    localparam int FLAG_C  = 0;
    localparam int FLAG_Z  = 1;
    localparam int FLAG_OV = 2;
    localparam int FLAG_N  = 3;
    localparam int FLAG_HZ = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_STEP_WAIT = 3'd5,
        S_HALTED    = 3'd6
    } cpu_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic logic [4:0] set_zn(input logic [4:0] f, input logic [15:0] r);
        logic [4:0] o;
        o         = f;
        o[FLAG_Z] = (r == 16'h0000);
        o[FLAG_N] = r[15];
        return o;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver, LSB first.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rx              serial line (idle high), synchronised internally
//   data, valid     received byte and its one-cycle strobe
//   state           receiver state, for observation
// The start bit is re-checked at mid-bit to reject glitches; data and stop
// bits are sampled at mid-bit. A low stop bit drops the byte. The receiver
// returns to idle in the middle of the stop bit, so any amount of extra
// idle line between bytes is accepted.
module uart_rx
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output rx_state_e  state
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_e     state_nx;
    logic          rx_meta;
    logic          rx_sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RX_IDLE:  if (!rx_sync) state_nx = RX_START;
            // a line that is high again at mid start bit was a glitch
            RX_START: if (cnt == HALF_LAST) state_nx = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt == FULL_LAST && bit_idx == 3'd7) state_nx = RX_STOP;
            RX_STOP:  if (cnt == FULL_LAST) state_nx = RX_IDLE;
            default:  state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            data    <= 8'h00;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= 3'd0;
                end
                RX_START: cnt <= (cnt == HALF_LAST) ? '0 : cnt + 1'b1;
                RX_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            data  <= shreg;
                            valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/cpu_top.sv
// cpu_top -- accumulator CPU whose program arrives over a UART.
// Optional feature macro: CPU_MPY_EN (signed 16x16 multiply, opcode 0x1).
// Without it opcode 0x1 is a NOP and MR / HZ stay zero.
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_rx                     UART line carrying program bytes
//   ctrl_step_execution      1 = pause after each instruction
//   i_user_sample            display snapshot pulse (step mode)
//   i_start_cpu              run enable level
//   i_next_instr_stimulus    step-advance pulse
//   o_instr_transmit_done    program ended with HALT and is loaded
//   o_max_addr               last written instruction address
//   o_halt                   HALT executed
//   o_alu_result_low/high    ACC / MR display
//   o_flags                  {HZ,N,OV,Z,C} display
//   o_current_Opcode/PC      fetched byte0 / PC display
//   dbg_state, dbg_rx_state  live sequencer and receiver states
// Instructions are {byte0,byte1}: opcode byte0[7:4], immediate flag byte0[0],
// operand byte1. EXECUTE only computes results; WRITEBACK commits them, so a
// run aborted by i_start_cpu dropping never half-applies an instruction.
module cpu_top
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int MEM_DEPTH    = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx,
    input  logic        ctrl_step_execution,
    input  logic        i_user_sample,
    input  logic        i_start_cpu,
    input  logic        i_next_instr_stimulus,
    output logic        o_instr_transmit_done,
    output logic [7:0]  o_max_addr,
    output logic        o_halt,
    output logic [15:0] o_alu_result_low,
    output logic [15:0] o_alu_result_high,
    output logic [4:0]  o_flags,
    output logic [7:0]  o_current_Opcode,
    output logic [7:0]  o_current_PC,
    output logic [2:0]  dbg_state,
    output logic [1:0]  dbg_rx_state
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // receiver
    logic [7:0] rx_data;
    logic       rx_valid;
    rx_state_e  rx_state;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .rx    (i_rx),
        .data  (rx_data),
        .valid (rx_valid),
        .state (rx_state)
    );

    // memories (contents survive reset)
    logic [15:0] imem [MEM_DEPTH];
    logic [15:0] dmem [MEM_DEPTH];

    // loader
    logic       lo_half;
    logic [7:0] lo_byte0;
    logic [7:0] load_ptr;
    logic [7:0] max_addr;
    logic       done;
    logic       imem_we;

    // cpu registers
    cpu_state_e  state, state_nx;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [15:0] op_val;
    logic [15:0] acc, mr;
    logic [4:0]  flags;
    logic [15:0] res_acc, res_mr;
    logic [4:0]  res_flags;
    logic        res_jump;
    logic        halt;
    logic        dmem_we;
    logic [3:0]  opc;

    // pulse edge detection
    logic next_prev, sample_prev;
    logic next_rise, sample_rise;

    // display registers
    logic [15:0] disp_acc, disp_mr;
    logic [4:0]  disp_flags;
    logic [7:0]  disp_opc, disp_pc;

    // alu
    logic [15:0] alu_acc, alu_mr;
    logic [4:0]  alu_flags;
    logic        alu_jump;
    logic [16:0] sum;
    logic [15:0] diff;
`ifdef CPU_MPY_EN
    logic signed [31:0] prod;
`endif

    assign opc         = ir[15:12];
    assign next_rise   = i_next_instr_stimulus & ~next_prev;
    assign sample_rise = i_user_sample & ~sample_prev;
    assign imem_we     = rx_valid && !done && lo_half;
    // STORE commits together with the other results of its instruction
    assign dmem_we     = (state == S_WRITEBACK) && (opc == OP_STORE);

    always_ff @(posedge i_clk) begin
        if (imem_we) imem[load_ptr[AW-1:0]] <= {lo_byte0, rx_data};
        if (dmem_we) dmem[ir[AW-1:0]] <= acc;
    end

    // Byte pairing; everything after the HALT instruction is ignored.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lo_half  <= 1'b0;
            lo_byte0 <= 8'h00;
            load_ptr <= 8'h00;
            max_addr <= 8'h00;
            done     <= 1'b0;
        end else if (rx_valid && !done) begin
            if (!lo_half) begin
                lo_byte0 <= rx_data;
                lo_half  <= 1'b1;
            end else begin
                lo_half  <= 1'b0;
                max_addr <= load_ptr;
                load_ptr <= load_ptr + 8'd1;
                if (lo_byte0[7:4] == OP_HALT) done <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            next_prev   <= 1'b0;
            sample_prev <= 1'b0;
        end else begin
            next_prev   <= i_next_instr_stimulus;
            sample_prev <= i_user_sample;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (done) state_nx = S_FETCH;
            S_FETCH:     state_nx = S_DECODE;
            S_DECODE:    state_nx = S_EXECUTE;
            S_EXECUTE:   state_nx = (opc == OP_HALT) ? S_HALTED : S_WRITEBACK;
            S_WRITEBACK: state_nx = ctrl_step_execution ? S_STEP_WAIT : S_FETCH;
            S_STEP_WAIT: if (next_rise) state_nx = S_FETCH;
            S_HALTED:    state_nx = S_HALTED;
            default:     state_nx = S_IDLE;
        endcase
        // dropping the run enable parks the sequencer from any state
        if (!i_start_cpu) state_nx = S_IDLE;
    end

    always_comb begin
        alu_acc   = acc;
        alu_mr    = mr;
        alu_flags = flags;
        alu_jump  = 1'b0;
        sum       = {1'b0, acc} + {1'b0, op_val};
        diff      = acc - op_val;
`ifdef CPU_MPY_EN
        prod      = $signed(acc) * $signed(op_val);
`endif
        case (opc)
`ifdef CPU_MPY_EN
            OP_MPY: begin
                alu_acc            = prod[15:0];
                alu_mr             = prod[31:16];
                alu_flags          = set_zn(flags, prod[15:0]);
                alu_flags[FLAG_HZ] = |prod[31:16];
            end
`endif
            OP_ADD: begin
                alu_acc            = sum[15:0];
                alu_flags          = set_zn(flags, sum[15:0]);
                alu_flags[FLAG_C]  = sum[16];
                alu_flags[FLAG_OV] = (acc[15] == op_val[15]) && (sum[15] != acc[15]);
            end
            OP_SUB: begin
                alu_acc            = diff;
                alu_flags          = set_zn(flags, diff);
                alu_flags[FLAG_C]  = (acc >= op_val);
                alu_flags[FLAG_OV] = (acc[15] != op_val[15]) && (diff[15] != acc[15]);
            end
            OP_AND: begin
                alu_acc   = acc & op_val;
                alu_flags = set_zn(flags, acc & op_val);
            end
            OP_OR: begin
                alu_acc   = acc | op_val;
                alu_flags = set_zn(flags, acc | op_val);
            end
            OP_NOT: begin
                alu_acc   = ~acc;
                alu_flags = set_zn(flags, ~acc);
            end
            OP_LOAD: begin
                alu_acc   = op_val;
                alu_flags = set_zn(flags, op_val);
            end
            OP_SHR: begin
                alu_acc   = acc >> op_val[3:0];
                alu_flags = set_zn(flags, acc >> op_val[3:0]);
            end
            OP_SHL: begin
                alu_acc   = acc << op_val[3:0];
                alu_flags = set_zn(flags, acc << op_val[3:0]);
            end
            OP_JGZ:  alu_jump = ($signed(acc) > 16'sd0);
            OP_JMP:  alu_jump = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc        <= 8'h00;
            ir        <= 16'h0000;
            op_val    <= 16'h0000;
            acc       <= 16'h0000;
            mr        <= 16'h0000;
            flags     <= 5'b00000;
            res_acc   <= 16'h0000;
            res_mr    <= 16'h0000;
            res_flags <= 5'b00000;
            res_jump  <= 1'b0;
            halt      <= 1'b0;
        end else begin
            case (state)
                S_FETCH:  ir <= imem[pc[AW-1:0]];
                S_DECODE: op_val <= ir[8] ? {8'h00, ir[7:0]} : dmem[ir[AW-1:0]];
                S_EXECUTE: begin
                    res_acc   <= alu_acc;
                    res_mr    <= alu_mr;
                    res_flags <= alu_flags;
                    res_jump  <= alu_jump;
                    if (opc == OP_HALT) halt <= 1'b1;
                end
                S_WRITEBACK: begin
                    acc   <= res_acc;
                    mr    <= res_mr;
                    flags <= res_flags;
                    pc    <= res_jump ? ir[7:0] : pc + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Step mode freezes the display between snapshots; the snapshot sees the
    // registers as they stand before any simultaneous step advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            disp_acc   <= 16'h0000;
            disp_mr    <= 16'h0000;
            disp_flags <= 5'b00000;
            disp_opc   <= 8'h00;
            disp_pc    <= 8'h00;
        end else if (!ctrl_step_execution || sample_rise) begin
            disp_acc   <= acc;
            disp_mr    <= mr;
            disp_flags <= flags;
            disp_opc   <= ir[15:8];
            disp_pc    <= pc;
        end
    end

    assign o_instr_transmit_done = done;
    assign o_max_addr            = max_addr;
    assign o_halt                = halt;
    assign o_alu_result_low      = disp_acc;
    assign o_alu_result_high     = disp_mr;
    assign o_flags               = disp_flags;
    assign o_current_Opcode      = disp_opc;
    assign o_current_PC          = disp_pc;
    assign dbg_state             = state;
    assign dbg_rx_state          = rx_state;

endmodule

// File: tb/tb_cpu_top.sv
// tb_cpu_top -- directed bench for cpu_top: UART program loading, step and
// free-running execution, flag behaviour, reset recovery.
module tb_cpu_top;
    import cpu_pkg::*;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        step = 1'b0;
    logic        user_sample = 1'b0;
    logic        start_cpu = 1'b0;
    logic        next_instr = 1'b0;
    logic        done;
    logic [7:0]  max_addr;
    logic        halt;
    logic [15:0] acc_out, mr_out;
    logic [4:0]  flags_out;
    logic [7:0]  opc_out, pc_out;
    logic [2:0]  dbg_state;
    logic [1:0]  dbg_rx_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] prog [$];

    cpu_top #(.CLKS_PER_BIT(CPB), .MEM_DEPTH(256)) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_rx                  (rx),
        .ctrl_step_execution   (step),
        .i_user_sample         (user_sample),
        .i_start_cpu           (start_cpu),
        .i_next_instr_stimulus (next_instr),
        .o_instr_transmit_done (done),
        .o_max_addr            (max_addr),
        .o_halt                (halt),
        .o_alu_result_low      (acc_out),
        .o_alu_result_high     (mr_out),
        .o_flags               (flags_out),
        .o_current_Opcode      (opc_out),
        .o_current_PC          (pc_out),
        .dbg_state             (dbg_state),
        .dbg_rx_state          (dbg_rx_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic load_prog();
        foreach (prog[i]) send_byte(prog[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int k = 0;
        while (dbg_state !== s && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {29'd0, dbg_state}, {29'd0, s});
    endtask

    task automatic wait_halt(input int budget, input string tag);
        int k = 0;
        while (halt !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, halt}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_sample();
        @(negedge clk) user_sample = 1'b1;
        @(negedge clk) user_sample = 1'b0;
    endtask

    task automatic pulse_next();
        @(negedge clk) next_instr = 1'b1;
        @(negedge clk) next_instr = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"},  {31'd0, done},      32'd0);
        check({tag, "_maxa"},  {24'd0, max_addr},  32'd0);
        check({tag, "_halt"},  {31'd0, halt},      32'd0);
        check({tag, "_acc"},   {16'd0, acc_out},   32'd0);
        check({tag, "_mr"},    {16'd0, mr_out},    32'd0);
        check({tag, "_flags"}, {27'd0, flags_out}, 32'd0);
        check({tag, "_opc"},   {24'd0, opc_out},   32'd0);
        check({tag, "_pc"},    {24'd0, pc_out},    32'd0);
    endtask

    // free-running execution of a program that ends in HALT
    task automatic run_prog(input string tag);
        do_reset();
        step      = 1'b0;
        start_cpu = 1'b0;
        load_prog();
        start_cpu = 1'b1;
        wait_halt(2000, {tag, "_halt"});
    endtask

    initial begin
        // ---- reset state ----
        do_reset();
        check_zero("rst");

        // ---- load + step run: LOAD #5, ADD #3, HALT ----
        step = 1'b1;
        prog = '{8'h41, 8'h05, 8'hC1, 8'h03, 8'hE0, 8'h00};
        load_prog();
        check("a_done", {31'd0, done}, 32'd1);
        check("a_maxa", {24'd0, max_addr}, 32'd2);
        start_cpu = 1'b1;
        wait_state(S_STEP_WAIT, 50, "a_wait1");
        // display frozen until the first snapshot
        check("a_frozen_acc", {16'd0, acc_out}, 32'd0);
        repeat (30) @(negedge clk);
        check("a_hold_state", {29'd0, dbg_state}, {29'd0, S_STEP_WAIT});
        pulse_sample();
        check("a_s1_pc", {24'd0, pc_out}, 32'd1);
        check("a_s1_acc", {16'd0, acc_out}, 32'h0005);
        check("a_s1_opc", {24'd0, opc_out}, 32'h41);
        pulse_next();
        wait_state(S_STEP_WAIT, 50, "a_wait2");
        check("a_prefrz_pc", {24'd0, pc_out}, 32'd1);
        pulse_sample();
        check("a_s2_pc", {24'd0, pc_out}, 32'd2);
        check("a_s2_acc", {16'd0, acc_out}, 32'h0008);
        check("a_s2_flags", {27'd0, flags_out}, 32'h00);
        pulse_next();
        wait_halt(50, "a_halt");
        pulse_sample();
        check("a_s3_acc", {16'd0, acc_out}, 32'h0008);
        check("a_s3_opc", {24'd0, opc_out}, 32'hE0);

        // ---- LOAD #7F, STORE 10, LOAD #1, ADD [10], HALT ----
        prog = '{8'h41, 8'h7F, 8'h80, 8'h10, 8'h41, 8'h01, 8'hC0, 8'h10, 8'hE0, 8'h00};
        run_prog("b");
        check("b_maxa", {24'd0, max_addr}, 32'd4);
        check("b_acc", {16'd0, acc_out}, 32'h0080);
        check("b_flags", {27'd0, flags_out}, 32'h00);

        // ---- LOAD #0, SUB #1, JGZ 7 (not taken), HALT ----
        prog = '{8'h41, 8'h00, 8'h21, 8'h01, 8'hA0, 8'h07, 8'hE0, 8'h00};
        run_prog("c");
        check("c_acc", {16'd0, acc_out}, 32'hFFFF);
        check("c_flags", {27'd0, flags_out}, 32'h08);
        check("c_pc", {24'd0, pc_out}, 32'd3);

        // ---- LOAD #1, JGZ 3 (taken), LOAD #2 (skipped), SHL #15, SUB #1, HALT ----
        // 0x8000 - 1 = 0x7FFF: signed overflow, no borrow
        prog = '{8'h41, 8'h01, 8'hA0, 8'h03, 8'h41, 8'h02, 8'hB1, 8'h0F,
                 8'h21, 8'h01, 8'hE0, 8'h00};
        run_prog("d");
        check("d_acc", {16'd0, acc_out}, 32'h7FFF);
        check("d_flags", {27'd0, flags_out}, 32'h05);
        check("d_pc", {24'd0, pc_out}, 32'd5);

        // ---- LOAD #FF, SHL #8, JMP 4, LOAD #0, OR #FF, ADD #2, NOT, SHR #4, AND #F0, HALT ----
        // FFFF+2 carries out to 0x0001; later ops keep C, refresh Z/N
        prog = '{8'h41, 8'hFF, 8'hB1, 8'h08, 8'hD0, 8'h04, 8'h41, 8'h00,
                 8'h51, 8'hFF, 8'hC1, 8'h02, 8'h60, 8'h00, 8'h91, 8'h04,
                 8'h31, 8'hF0, 8'hE0, 8'h00};
        run_prog("e");
        check("e_maxa", {24'd0, max_addr}, 32'd9);
        check("e_acc", {16'd0, acc_out}, 32'h00F0);
        check("e_flags", {27'd0, flags_out}, 32'h01);
        check("e_pc", {24'd0, pc_out}, 32'd9);

        // ---- LOAD #FF, MPY #FF, HALT ----
        prog = '{8'h41, 8'hFF, 8'h11, 8'hFF, 8'hE0, 8'h00};
        run_prog("f");
`ifdef CPU_MPY_EN
        check("f_acc", {16'd0, acc_out}, 32'hFE01);
        check("f_mr", {16'd0, mr_out}, 32'h0000);
        check("f_hz", {31'd0, flags_out[FLAG_HZ]}, 32'd0);
`else
        check("f_acc", {16'd0, acc_out}, 32'h00FF);
        check("f_mr", {16'd0, mr_out}, 32'h0000);
        check("f_flags", {27'd0, flags_out}, 32'h00);
`endif

        // ---- endless LOAD #5 / JMP 0 loop, then reset mid-run and mid-byte ----
        prog = '{8'h41, 8'h05, 8'hD0, 8'h00, 8'hE0, 8'h00};
        do_reset();
        step      = 1'b0;
        start_cpu = 1'b0;
        load_prog();
        start_cpu = 1'b1;
        repeat (60) @(negedge clk);
        check("g_run_acc", {16'd0, acc_out}, 32'h0005);
        check("g_run_halt", {31'd0, halt}, 32'd0);
        rx = 1'b0;
        repeat (CPB + CPB / 2 + 3) @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("g_inrst");
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        prog = '{8'h41, 8'h00};
        load_prog();
        check_zero("g_reload");
        check("g_state", {29'd0, dbg_state}, {29'd0, S_IDLE});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
